// File: rtl/shift_seq_reg.sv
// Multi-function shift/rotate/load register with an LSB-first serialize burst.
// Define SHIFT_SEQ_PARITY_EN to add a registered even-parity output on par.
module shift_seq_reg #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2:0]    ctrl,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  d,
    input  logic          si,
    output logic [N-1:0]  q,
    output logic          so,
    output logic          busy,
    output logic          done,
    output logic          par
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_p0, state_p1;
    logic [N-1:0]  q_p0, q_p1;
    logic [AW-1:0] cnt_p0, cnt_p1;
    logic          done_p0, done_p1;

    function automatic logic [N-1:0] shl_fill(input logic [N-1:0] v, input logic [AW-1:0] s,
                                              input logic fill);
        logic [N-1:0] ones;
        ones = '1;
        return (v << s) | (fill ? ~(ones << s) : '0);
    endfunction

    function automatic logic [N-1:0] shr_fill(input logic [N-1:0] v, input logic [AW-1:0] s,
                                              input logic fill);
        logic [N-1:0] ones;
        ones = '1;
        return (v >> s) | (fill ? ~(ones >> s) : '0);
    endfunction

    function automatic logic [N-1:0] rot_left(input logic [N-1:0] v, input logic [AW-1:0] s);
        logic [2*N-1:0] w;
        w = {v, v} << s;
        return w[2*N-1:N];
    endfunction

    function automatic logic [N-1:0] rot_right(input logic [N-1:0] v, input logic [AW-1:0] s);
        logic [2*N-1:0] w;
        w = {v, v} >> s;
        return w[N-1:0];
    endfunction

    function automatic logic [N-1:0] asr(input logic [N-1:0] v, input logic [AW-1:0] s);
        logic signed [N-1:0] sv;
        sv = v;
        sv = sv >>> s;
        return sv;
    endfunction

    // Stage p0: next-state and datapath selection
    always_comb begin
        state_p0 = state_p1;
        q_p0     = q_p1;
        cnt_p0   = cnt_p1;
        done_p0  = 1'b0;
        case (state_p1)
            S_IDLE: begin
                if (en) begin
                    case (ctrl)
                        3'b001: q_p0 = shl_fill(q_p1, amt, si);
                        3'b010: q_p0 = shr_fill(q_p1, amt, si);
                        3'b011: q_p0 = d;
                        3'b100: q_p0 = rot_left(q_p1, amt);
                        3'b101: q_p0 = rot_right(q_p1, amt);
                        3'b110: q_p0 = asr(q_p1, amt);
                        3'b111: begin
                            q_p0     = d;
                            cnt_p0   = '0;
                            state_p0 = S_BURST;
                        end
                        default: q_p0 = q_p1;
                    endcase
                end
            end
            S_BURST: begin
                // en/ctrl are ignored; the last shift happens on the edge that ends the burst
                q_p0 = {si, q_p1[N-1:1]};
                if (cnt_p1 == AW'(N - 1)) begin
                    state_p0 = S_IDLE;
                    done_p0  = 1'b1;
                    cnt_p0   = '0;
                end else begin
                    cnt_p0 = cnt_p1 + 1'b1;
                end
            end
            default: state_p0 = S_IDLE;
        endcase
    end

    // Stage p1: registered state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1 <= S_IDLE;
            q_p1     <= '0;
            cnt_p1   <= '0;
            done_p1  <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            q_p1     <= q_p0;
            cnt_p1   <= cnt_p0;
            done_p1  <= done_p0;
        end
    end

`ifdef SHIFT_SEQ_PARITY_EN
    logic par_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_p1 <= 1'b0;
        end else begin
            par_p1 <= ^q_p0;
        end
    end

    assign par = par_p1;
`else
    assign par = 1'b0;
`endif

    assign q    = q_p1;
    assign so   = q_p1[0];
    assign busy = (state_p1 == S_BURST);
    assign done = done_p1;

endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed bench for shift_seq_reg: reset, shift/rotate ops, serialize bursts, abort, parity.
module tb_shift_seq_reg;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          en;
    logic [2:0]    ctrl;
    logic [AW-1:0] amt;
    logic [N-1:0]  d;
    logic          si;
    logic [N-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;
    logic          par;

    int n_tests = 0;
    int n_fail  = 0;

    shift_seq_reg #(.N(N), .AW(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .ctrl (ctrl),
        .amt  (amt),
        .d    (d),
        .si   (si),
        .q    (q),
        .so   (so),
        .busy (busy),
        .done (done),
        .par  (par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] c, input logic [AW-1:0] a, input logic [N-1:0] dv,
                      input logic s);
        en   = 1'b1;
        ctrl = c;
        amt  = a;
        d    = dv;
        si   = s;
        tick();
    endtask

    initial begin
        logic [N-1:0] stream;
        logic         par_07;

`ifdef SHIFT_SEQ_PARITY_EN
        par_07 = 1'b1;
`else
        par_07 = 1'b0;
`endif
        reset = 1'b1;
        en    = 1'b0;
        ctrl  = 3'b000;
        amt   = '0;
        d     = '0;
        si    = 1'b0;

        // asynchronous reset assertion, no clock edge involved
        #2 reset = 1'b0;
        #1;
        check("reset_q", q, 8'h00);
        check("reset_busy", {7'b0, busy}, 8'h00);
        check("reset_done", {7'b0, done}, 8'h00);
        check("reset_par", {7'b0, par}, 8'h00);

        // operations are blocked while reset is held
        en = 1'b1; ctrl = 3'b011; d = 8'hA5;
        tick();
        tick();
        check("reset_hold_q", q, 8'h00);

        reset = 1'b1;
        op(3'b011, 3'd0, 8'hA5, 1'b0);
        check("load_A5", q, 8'hA5);
        check("so_eq_q0", {7'b0, so}, 8'h01);

        op(3'b001, 3'd3, 8'h00, 1'b1);
        check("shl3_si1", q, 8'h2F);
        op(3'b101, 3'd1, 8'h00, 1'b0);
        check("rotr1", q, 8'h97);
        op(3'b110, 3'd2, 8'h00, 1'b0);
        check("asr2", q, 8'hE5);
        op(3'b100, 3'd0, 8'h00, 1'b1);
        check("rotl0_hold", q, 8'hE5);
        op(3'b001, 3'd0, 8'h00, 1'b1);
        check("shl0_hold", q, 8'hE5);
        op(3'b100, 3'd4, 8'h00, 1'b0);
        check("rotl4", q, 8'h5E);
        op(3'b010, 3'd2, 8'h00, 1'b0);
        check("shr2_si0", q, 8'h17);
        op(3'b010, 3'd3, 8'h00, 1'b1);
        check("shr3_si1", q, 8'hE2);
        op(3'b110, 3'd3, 8'h00, 1'b0);
        check("asr3_neg", q, 8'hFC);
        op(3'b000, 3'd0, 8'h00, 1'b0);
        check("ctrl_hold", q, 8'hFC);
        en = 1'b0; ctrl = 3'b011; d = 8'h11;
        tick();
        check("en0_hold", q, 8'hFC);

        // serialize 3C; ctrl scrambled mid-burst must be ignored
        op(3'b111, 3'd0, 8'h3C, 1'b0);
        stream = 8'h3C;
        for (int i = 0; i < N; i++) begin
            check($sformatf("ser_busy_%0d", i), {7'b0, busy}, 8'h01);
            check($sformatf("ser_so_%0d", i), {7'b0, so}, {7'b0, stream[i]});
            check($sformatf("ser_done_%0d", i), {7'b0, done}, 8'h00);
            if (i == 1) begin ctrl = 3'b011; d = 8'hFF; end
            if (i == 3) begin ctrl = 3'b001; amt = 3'd1; si = 1'b0; end
            if (i == 5) begin ctrl = 3'b111; d = 8'h55; end
            if (i == 7) ctrl = 3'b000;
            tick();
        end
        check("ser_end_busy", {7'b0, busy}, 8'h00);
        check("ser_end_done", {7'b0, done}, 8'h01);
        check("ser_end_q", q, 8'h00);
        tick();
        check("ser_done_once", {7'b0, done}, 8'h00);
        check("ser_after_q", q, 8'h00);

        // back-to-back: second start issued on the done cycle
        op(3'b111, 3'd0, 8'h81, 1'b0);
        stream = 8'h81;
        for (int i = 0; i < N; i++) begin
            check($sformatf("b2b1_busy_%0d", i), {7'b0, busy}, 8'h01);
            check($sformatf("b2b1_so_%0d", i), {7'b0, so}, {7'b0, stream[i]});
            d = 8'hFF;
            tick();
        end
        check("b2b_done", {7'b0, done}, 8'h01);
        si = 1'b1;
        tick();
        check("b2b2_start_q", q, 8'hFF);
        for (int i = 0; i < N; i++) begin
            check($sformatf("b2b2_busy_%0d", i), {7'b0, busy}, 8'h01);
            check($sformatf("b2b2_so_%0d", i), {7'b0, so}, 8'h01);
            if (i == 7) ctrl = 3'b000;
            tick();
        end
        check("b2b2_end_done", {7'b0, done}, 8'h01);
        check("b2b2_end_q", q, 8'hFF);
        tick();

        // abort: reset during 4th busy cycle
        op(3'b111, 3'd0, 8'h3C, 1'b0);
        ctrl = 3'b000;
        tick();
        tick();
        tick();
        check("abort_pre_busy", {7'b0, busy}, 8'h01);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {7'b0, busy}, 8'h00);
        check("abort_q", q, 8'h00);
        check("abort_so", {7'b0, so}, 8'h00);
        check("abort_done", {7'b0, done}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 2) reset = 1'b1;
            check($sformatf("abort_nodone_%0d", i), {7'b0, done}, 8'h00);
        end
        check("abort_idle", {7'b0, busy}, 8'h00);

        // parity
        op(3'b011, 3'd0, 8'h07, 1'b0);
        check("par_07", {7'b0, par}, {7'b0, par_07});
        op(3'b011, 3'd0, 8'h03, 1'b0);
        check("par_03", {7'b0, par}, 8'h00);
        op(3'b001, 3'd1, 8'h00, 1'b1);
        check("par_shl_q", q, 8'h07);
        check("par_shl", {7'b0, par}, {7'b0, par_07});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
